hazard3_pmp_tor: RTL and testbench
==================================

Name: hazard3_pmp_tor

Overview:
Second-generation physical memory protection unit. Adds TOR matching, a configurable region count up to 16, and full-access (multi-byte) checking.
- Each query takes one cycle and returns a registered response.
- The first failing access is latched in a sticky fault-capture register, readable through the custom CSRs.
- Sits beside the CSR block; it services either the fetch or the load/store checker instance.

Parameters:
PMP_REGIONS, 16, number of implemented regions (1..16, mapped onto pmpcfg0..3).
PMP_GRAIN, 0, G: region granularity is 2^(G+2) bytes.
W_ADDR, 32, physical address width.
TOR_EN, 1, when 1 TOR mode is supported; when 0, writes of TOR map to OFF.
CSR_FAULT_ADDR, 12'hbd0, custom CSR returning the captured fault address.
CSR_FAULT_INFO, 12'hbd1, custom CSR returning fault status; writing bit0=1 clears the capture.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mstatus_mxr  in  1  make-executable-readable
cfg_addr  in  12  CSR address
cfg_wen  in  1  CSR write strobe
cfg_wdata  in  32  CSR write data
cfg_rdata  out  32  CSR read data (combinational)
q_valid  in  1  query strobe
q_addr  in  W_ADDR  first byte of the access
q_size  in  2  access size: 0=1 byte, 1=2 bytes, 2=4 bytes (3 treated as 4)
q_type  in  2  access type: 0=read, 1=write, 2=execute
q_m_mode  in  1  privilege is M-mode
r_valid  out  1  response valid
r_kill  out  1  access denied
r_region  out  5  matching region index; 5'h1f = no match

Behaviour:
Interface
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset values: r_valid=0, r_kill=0, r_region=5'h1f, fault_valid=0, fault address=0, fault info=0.
- Reset values for region config: all cfg fields 0; pmpaddr = 0.

Config fields
- pmpcfgN fields (L, A, X, W, R) are stored; bits 6:5 read as zero.
- A is WARL:
  - TOR maps to OFF when TOR_EN=0.
  - NA4 maps to OFF when G>0.
- pmpaddr readback:
  - When G≥1 and A is OFF or TOR, bits G-1:0 read as 0.
  - When G≥2 and A is NAPOT, bits G-2:0 read as 1.

Locking
- L=1 on region i blocks writes to pmpcfg i and pmpaddr i.
- If region i+1 has L=1 and A=TOR, pmpaddr i is also write-blocked.
- L persists until reset.

Match rules
- Address range:
  - TOR: the lower bound for region i is pmpaddr[i-1]<<2, or 0 when i=0.
  - TOR: region i matches when lower bound ≤ addr < pmpaddr[i]<<2.
  - TOR with pmpaddr[i] ≤ lower bound matches nothing.
  - NA4: 4-byte region.
  - NAPOT: size given by the trailing ones of pmpaddr.
- Full-access check:
  - Evaluate both the first byte (q_addr) and the last byte (q_addr+size-1) against each region.
  - The lowest-numbered region matching either byte wins.
  - If that region matches only one of the two bytes, the access is killed, regardless of L/R/W/X and of privilege.
  - Last-byte address arithmetic wraps modulo 2^W_ADDR.

Permission rules
- Permission is bypassed when q_m_mode=1 and L=0.
- Otherwise:
  - read requires R, or X with mstatus_mxr=1;
  - write requires W;
  - execute requires X.
- No region matches: M-mode is allowed; non-M-mode is killed.

Timing
- r_valid = q_valid delayed by 1 cycle.
- r_kill and r_region are registered from the query cycle and hold their value while r_valid=0.
- A CSR write in the same cycle as a query: the query sees the pre-write config.

Fault capture
- Captures on r_valid && r_kill && !fault_valid.
- Captured data: {q_addr, q_type, r_region}, taken from the query-cycle pipeline register.
- FAULT_INFO layout: bit0 = fault_valid, bits 2:1 = type, bits 8:4 = region.
- Captured data is held until cleared by a FAULT_INFO write with bit0=1.
- A clear in the same cycle as a new fault: the new fault is captured (fault_valid stays 1 with the new data).
- Reset mid-query: the pipeline register and the capture are both cleared.

Decomposition:
- Shared constants in hazard3_csr_addr.vh: PMPCFG0, PMPADDR0, and the PMP_A_* encodings.
- Add the fault CSR addresses to the shared config.
- One sub-module, hazard3_pmp_region_match:
  - one instance per region;
  - inputs: cfg, pmpaddr, lower bound, two addresses;
  - outputs: match_first, match_last.
- The top level contains the priority encoder, the registers and the capture logic.

Test Plan:
- Reset -> all cfg/addr CSRs read 0; r_valid=0; FAULT_INFO=0; U-mode read of 0x0 one cycle later gives r_kill=1, r_region=31.
- Region0 TOR with pmpaddr0=0x400 (top 0x1000), R=1; U-mode 4-byte reads at 0xffc and 0x1000 -> kill=0, region=0, then kill=1, region=31.
- Region1 NAPOT at 0x2000, size 0x100, X only; U-mode 4-byte execute at 0x20fe -> partial match, kill=1. Read at 0x2000 -> kill=1; with mxr=1 -> kill=0.
- Region2 TOR, L=1 -> writes to pmpaddr1, pmpaddr2 and pmpcfg0 byte2 are ignored; M-mode write into region2 with W=0 -> kill=1.
- Two consecutive U-mode faults -> FAULT_ADDR holds the first; clear coincident with a third fault -> third captured, fault_valid stays 1.
- G=2, NAPOT: read pmpaddr -> bit0 reads 1; set A=OFF -> bits 1:0 read 0. With G=2, writing A=NA4 -> reads back OFF.

Source files
------------

// File: rtl/hazard3_pmp_tor_pkg.sv
// Shared PMP constants, config encodings and the pmpaddr readback helper.
// Imported by the PMP top level, its region matcher and the query interface users.
package hazard3_pmp_tor_pkg;

   localparam logic [11:0] PMPCFG0  = 12'h3a0;
   localparam logic [11:0] PMPADDR0 = 12'h3b0;
   localparam logic [11:0] CSR_FAULT_ADDR_DEF = 12'hbd0;
   localparam logic [11:0] CSR_FAULT_INFO_DEF = 12'hbd1;

   typedef enum logic [1:0] {
      PMP_A_OFF   = 2'd0,
      PMP_A_TOR   = 2'd1,
      PMP_A_NA4   = 2'd2,
      PMP_A_NAPOT = 2'd3
   } pmp_a_t;

   typedef enum logic [1:0] {
      ACC_READ  = 2'd0,
      ACC_WRITE = 2'd1,
      ACC_EXEC  = 2'd2
   } acc_type_t;

   typedef struct packed {
      logic   l;
      pmp_a_t a;
      logic   x;
      logic   w;
      logic   r;
   } pmp_cfg_t;

   // Granule-adjusted pmpaddr: the value software reads back and the value matching uses.
   function automatic logic [31:0] pmp_addr_eff(input logic [31:0] raw, input pmp_a_t mode,
                                                input int unsigned g);
      logic [31:0] v;
      v = raw;
      if (mode == PMP_A_NAPOT) begin
         if (g >= 2) v = raw | ((32'd1 << (g - 1)) - 32'd1);
      end else if (mode != PMP_A_NA4) begin
         if (g >= 1) v = raw & ~((32'd1 << g) - 32'd1);
      end
      return v;
   endfunction

endpackage

// File: rtl/hazard3_pmp_tor_if.sv
// Query/response bundle between a fetch or load/store checker and the PMP.
interface hazard3_pmp_tor_if #(parameter int W_ADDR = 32);
   logic              q_valid;
   logic [W_ADDR-1:0] q_addr;
   logic [1:0]        q_size;
   logic [1:0]        q_type;
   logic              q_m_mode;
   logic              r_valid;
   logic              r_kill;
   logic [4:0]        r_region;

   modport master (output q_valid, q_addr, q_size, q_type, q_m_mode,
                   input  r_valid, r_kill, r_region);
   modport slave  (input  q_valid, q_addr, q_size, q_type, q_m_mode,
                   output r_valid, r_kill, r_region);
endinterface

// File: rtl/hazard3_pmp_region_match.sv
// Address match for one PMP region, evaluated for both first and last byte of an access.
// Addresses arrive as zero-extended word addresses (byte address >> 2).
module hazard3_pmp_region_match
   import hazard3_pmp_tor_pkg::*;
(
   input  pmp_a_t      mode,
   input  logic [31:0] pmpaddr,
   input  logic [31:0] lower,
   input  logic [31:0] wa_first,
   input  logic [31:0] wa_last,
   output logic        match_first,
   output logic        match_last
);

   logic [31:0] napot_care;

   // Trailing ones plus the next zero bit are don't-care address bits.
   assign napot_care = ~(pmpaddr ^ (pmpaddr + 32'd1));

   always_comb begin
      match_first = 1'b0;
      match_last  = 1'b0;
      case (mode)
         PMP_A_TOR: begin
            match_first = (wa_first >= lower) && (wa_first < pmpaddr);
            match_last  = (wa_last  >= lower) && (wa_last  < pmpaddr);
         end
         PMP_A_NA4: begin
            match_first = wa_first == pmpaddr;
            match_last  = wa_last  == pmpaddr;
         end
         PMP_A_NAPOT: begin
            match_first = ((wa_first ^ pmpaddr) & napot_care) == 32'd0;
            match_last  = ((wa_last  ^ pmpaddr) & napot_care) == 32'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard3_pmp_tor.sv
// PMP with TOR/NA4/NAPOT regions, full-access checking, one-cycle registered
// response and a sticky fault-capture register exposed through custom CSRs.
module hazard3_pmp_tor
   import hazard3_pmp_tor_pkg::*;
#(
   parameter int          PMP_REGIONS    = 16,
   parameter int          PMP_GRAIN      = 0,
   parameter int          W_ADDR         = 32,
   parameter bit          TOR_EN         = 1'b1,
   parameter logic [11:0] CSR_FAULT_ADDR = CSR_FAULT_ADDR_DEF,
   parameter logic [11:0] CSR_FAULT_INFO = CSR_FAULT_INFO_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mstatus_mxr,
   input  logic [11:0]             cfg_addr,
   input  logic                    cfg_wen,
   input  logic [31:0]             cfg_wdata,
   output logic [31:0]             cfg_rdata,
   hazard3_pmp_tor_if.slave        bus
);

   pmp_cfg_t                        cfg_reg [PMP_REGIONS];
   logic [31:0]                     addr_reg [PMP_REGIONS];
   logic [PMP_REGIONS-1:0][31:0]    addr_eff;
   logic [PMP_REGIONS-1:0]          cfg_l, tor_l, addr_lock;
   logic [PMP_REGIONS-1:0]          match_first, match_last;

   logic [1:0]        last_off;
   logic [W_ADDR-1:0] addr_last;
   logic [31:0]       wa_first, wa_last;

   logic       hit_any, hit_partial, hit_l, hit_r, hit_w, hit_x, kill_next;
   logic [4:0] hit_idx;

   logic              r_valid_reg, r_kill_reg;
   logic [4:0]        r_region_reg;
   logic [W_ADDR-1:0] q_addr_reg;
   logic [1:0]        q_type_reg;

   logic              fault_valid_reg, fault_clear;
   logic [W_ADDR-1:0] fault_addr_reg;
   logic [1:0]        fault_type_reg;
   logic [4:0]        fault_region_reg;

   function automatic pmp_cfg_t cfg_legalize(input logic [7:0] b);
      pmp_cfg_t c;
      c.l = b[7];
      c.a = pmp_a_t'(b[4:3]);
      c.x = b[2];
      c.w = b[1];
      c.r = b[0];
      if ((c.a == PMP_A_TOR && !TOR_EN) || (c.a == PMP_A_NA4 && PMP_GRAIN > 0))
         c.a = PMP_A_OFF;
      return c;
   endfunction

   // A locked TOR region also freezes the pmpaddr below it (its lower bound).
   always_comb begin
      for (int i = 0; i < PMP_REGIONS; i++) begin
         cfg_l[i] = cfg_reg[i].l;
         tor_l[i] = cfg_reg[i].l && cfg_reg[i].a == PMP_A_TOR;
      end
   end
   assign addr_lock = cfg_l | (tor_l >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PMP_REGIONS; i++) begin
            cfg_reg[i]  <= '0;
            addr_reg[i] <= '0;
         end
      end else if (cfg_wen) begin
         for (int i = 0; i < PMP_REGIONS; i++) begin
            if (cfg_addr == PMPCFG0 + 12'(i / 4) && !cfg_reg[i].l)
               cfg_reg[i] <= cfg_legalize(cfg_wdata[8 * (i % 4) +: 8]);
            if (cfg_addr == PMPADDR0 + 12'(i) && !addr_lock[i])
               addr_reg[i] <= cfg_wdata;
         end
      end
   end

   always_comb begin
      case (bus.q_size)
         2'd0:    last_off = 2'd0;
         2'd1:    last_off = 2'd1;
         default: last_off = 2'd3;
      endcase
   end
   assign addr_last = bus.q_addr + W_ADDR'(last_off);
   assign wa_first  = 32'(bus.q_addr[W_ADDR-1:2]);
   assign wa_last   = 32'(addr_last[W_ADDR-1:2]);

   genvar gi;
   generate
      for (gi = 0; gi < PMP_REGIONS; gi++) begin : g_region
         logic [31:0] lower;
         assign addr_eff[gi] = pmp_addr_eff(addr_reg[gi], cfg_reg[gi].a, PMP_GRAIN);
         if (gi == 0) begin : g_base
            assign lower = 32'd0;
         end else begin : g_chain
            assign lower = pmp_addr_eff(addr_reg[gi-1], PMP_A_TOR, PMP_GRAIN);
         end
         hazard3_pmp_region_match u_match (
            .mode        (cfg_reg[gi].a),
            .pmpaddr     (addr_eff[gi]),
            .lower       (lower),
            .wa_first    (wa_first),
            .wa_last     (wa_last),
            .match_first (match_first[gi]),
            .match_last  (match_last[gi])
         );
      end
   endgenerate

   // Descending scan so the lowest-numbered matching region wins.
   always_comb begin
      hit_any     = 1'b0;
      hit_partial = 1'b0;
      hit_idx     = 5'h1f;
      hit_l       = 1'b0;
      hit_r       = 1'b0;
      hit_w       = 1'b0;
      hit_x       = 1'b0;
      for (int i = PMP_REGIONS - 1; i >= 0; i--) begin
         if (match_first[i] || match_last[i]) begin
            hit_any     = 1'b1;
            hit_partial = match_first[i] ^ match_last[i];
            hit_idx     = 5'(i);
            hit_l       = cfg_reg[i].l;
            hit_r       = cfg_reg[i].r;
            hit_w       = cfg_reg[i].w;
            hit_x       = cfg_reg[i].x;
         end
      end
   end

   always_comb begin
      kill_next = 1'b0;
      if (!hit_any)
         kill_next = !bus.q_m_mode;
      else if (hit_partial)
         kill_next = 1'b1;
      else if (!(bus.q_m_mode && !hit_l)) begin
         case (acc_type_t'(bus.q_type))
            ACC_READ:  kill_next = !(hit_r || (hit_x && mstatus_mxr));
            ACC_WRITE: kill_next = !hit_w;
            default:   kill_next = !hit_x;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_reg  <= 1'b0;
         r_kill_reg   <= 1'b0;
         r_region_reg <= 5'h1f;
         q_addr_reg   <= '0;
         q_type_reg   <= '0;
      end else begin
         r_valid_reg <= bus.q_valid;
         if (bus.q_valid) begin
            r_kill_reg   <= kill_next;
            r_region_reg <= hit_idx;
            q_addr_reg   <= bus.q_addr;
            q_type_reg   <= bus.q_type;
         end
      end
   end

   assign bus.r_valid  = r_valid_reg;
   assign bus.r_kill   = r_kill_reg;
   assign bus.r_region = r_region_reg;

   assign fault_clear = cfg_wen && cfg_addr == CSR_FAULT_INFO && cfg_wdata[0];

   // A new fault takes priority over a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_valid_reg  <= 1'b0;
         fault_addr_reg   <= '0;
         fault_type_reg   <= '0;
         fault_region_reg <= '0;
      end else if (r_valid_reg && r_kill_reg && (!fault_valid_reg || fault_clear)) begin
         fault_valid_reg  <= 1'b1;
         fault_addr_reg   <= q_addr_reg;
         fault_type_reg   <= q_type_reg;
         fault_region_reg <= r_region_reg;
      end else if (fault_clear) begin
         fault_valid_reg  <= 1'b0;
         fault_addr_reg   <= '0;
         fault_type_reg   <= '0;
         fault_region_reg <= '0;
      end
   end

   always_comb begin
      cfg_rdata = 32'd0;
      for (int i = 0; i < PMP_REGIONS; i++) begin
         if (cfg_addr == PMPCFG0 + 12'(i / 4))
            cfg_rdata[8 * (i % 4) +: 8] = {cfg_reg[i].l, 2'b00, cfg_reg[i].a,
                                           cfg_reg[i].x, cfg_reg[i].w, cfg_reg[i].r};
         if (cfg_addr == PMPADDR0 + 12'(i))
            cfg_rdata = addr_eff[i];
      end
      if (cfg_addr == CSR_FAULT_ADDR)
         cfg_rdata = 32'(fault_addr_reg);
      if (cfg_addr == CSR_FAULT_INFO)
         cfg_rdata = {23'd0, fault_region_reg, 1'b0, fault_type_reg, fault_valid_reg};
   end

endmodule

// File: tb/tb_hazard3_pmp_tor.sv
// Directed bench: a 16-region G=0 PMP for matching/locking/fault capture and a
// 4-region G=2 PMP for granule readback and WARL legalisation.
module tb_hazard3_pmp_tor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mstatus_mxr = 1'b0;

   logic [11:0] cfg_addr0 = '0, cfg_addr1 = '0;
   logic        cfg_wen0 = 1'b0, cfg_wen1 = 1'b0;
   logic [31:0] cfg_wdata0 = '0, cfg_wdata1 = '0;
   logic [31:0] cfg_rdata0, cfg_rdata1;

   int n_checks = 0;
   int n_errors = 0;

   hazard3_pmp_tor_if #(.W_ADDR(32)) bus0 ();
   hazard3_pmp_tor_if #(.W_ADDR(32)) bus1 ();

   hazard3_pmp_tor #(.PMP_REGIONS(16), .PMP_GRAIN(0)) dut0 (
      .clk (clk), .rst_n (rst_n), .mstatus_mxr (mstatus_mxr),
      .cfg_addr (cfg_addr0), .cfg_wen (cfg_wen0), .cfg_wdata (cfg_wdata0),
      .cfg_rdata (cfg_rdata0), .bus (bus0)
   );

   hazard3_pmp_tor #(.PMP_REGIONS(4), .PMP_GRAIN(2)) dut1 (
      .clk (clk), .rst_n (rst_n), .mstatus_mxr (mstatus_mxr),
      .cfg_addr (cfg_addr1), .cfg_wen (cfg_wen1), .cfg_wdata (cfg_wdata1),
      .cfg_rdata (cfg_rdata1), .bus (bus1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input int u, input logic [11:0] a, input logic [31:0] d);
      if (u == 0) begin
         cfg_addr0 = a; cfg_wdata0 = d; cfg_wen0 = 1'b1;
      end else begin
         cfg_addr1 = a; cfg_wdata1 = d; cfg_wen1 = 1'b1;
      end
      tick();
      cfg_wen0 = 1'b0;
      cfg_wen1 = 1'b0;
      $display("csr%0d write %h <= %h", u, a, d);
   endtask

   task automatic csr_chk(input int u, input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] got;
      if (u == 0) cfg_addr0 = a; else cfg_addr1 = a;
      #1;
      got = (u == 0) ? cfg_rdata0 : cfg_rdata1;
      $display("csr%0d read  %h = %h  (%s)", u, a, got, tag);
      chk(tag, got, exp);
   endtask

   task automatic query(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic [1:0] typ, input logic m, input logic mxr,
                        input logic exp_kill, input logic [4:0] exp_region);
      bus0.q_valid = 1'b1; bus0.q_addr = addr; bus0.q_size = size;
      bus0.q_type = typ; bus0.q_m_mode = m; mstatus_mxr = mxr;
      tick();
      bus0.q_valid = 1'b0;
      $display("query %s addr=%h size=%0d type=%0d m=%0b mxr=%0b -> valid=%0b kill=%0b region=%0d",
               tag, addr, size, typ, m, mxr, bus0.r_valid, bus0.r_kill, bus0.r_region);
      chk({tag, ".valid"}, 32'(bus0.r_valid), 32'd1);
      chk({tag, ".kill"}, 32'(bus0.r_kill), 32'(exp_kill));
      chk({tag, ".region"}, 32'(bus0.r_region), 32'(exp_region));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus0.q_valid = 1'b0; bus0.q_addr = '0; bus0.q_size = '0; bus0.q_type = '0; bus0.q_m_mode = 1'b0;
      bus1.q_valid = 1'b0; bus1.q_addr = '0; bus1.q_size = '0; bus1.q_type = '0; bus1.q_m_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      chk("rst.r_valid", 32'(bus0.r_valid), 32'd0);
      chk("rst.r_region", 32'(bus0.r_region), 32'h1f);
      csr_chk(0, "rst.pmpcfg0", 12'h3a0, 32'h0);
      csr_chk(0, "rst.pmpcfg3", 12'h3a3, 32'h0);
      csr_chk(0, "rst.pmpaddr0", 12'h3b0, 32'h0);
      csr_chk(0, "rst.pmpaddr15", 12'h3bf, 32'h0);
      csr_chk(0, "rst.finfo", 12'hbd1, 32'h0);
      csr_chk(0, "rst.faddr", 12'hbd0, 32'h0);
      query("rst_u_read", 32'h0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'h1f);
      tick();
      chk("hold.valid", 32'(bus0.r_valid), 32'd0);
      chk("hold.kill", 32'(bus0.r_kill), 32'd1);
      chk("hold.region", 32'(bus0.r_region), 32'h1f);
      csr_chk(0, "first.finfo", 12'hbd1, 32'h1f1);
      csr_wr(0, 12'hbd1, 32'h1);
      csr_chk(0, "clr.finfo", 12'hbd1, 32'h0);

      // Reserved cfg bits 6:5 read as zero
      csr_wr(0, 12'h3a1, 32'h67);
      csr_chk(0, "cfg.resv", 12'h3a1, 32'h07);

      // Region0 TOR [0,0x1000) R
      csr_wr(0, 12'h3b0, 32'h400);
      csr_wr(0, 12'h3a0, 32'h09);
      csr_chk(0, "tor.cfg", 12'h3a0, 32'h09);
      csr_chk(0, "tor.addr", 12'h3b0, 32'h400);
      query("tor_in", 32'hffc, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      query("tor_top", 32'h1000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'h1f);
      query("tor_part_u", 32'hffe, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0);
      query("tor_part_m", 32'hffe, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 5'd0);
      query("nomatch_m", 32'h1000, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 5'h1f);

      // Region1 NAPOT 0x2000/0x100, X only
      csr_wr(0, 12'h3b1, 32'h81f);
      csr_wr(0, 12'h3a0, 32'h1c09);
      query("napot_xpart", 32'h20fe, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 5'd1);
      query("napot_x", 32'h20fc, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 5'd1);
      query("napot_r", 32'h2000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1);
      query("napot_r_mxr", 32'h2000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 5'd1);
      query("napot_w", 32'h2000, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 5'd1);

      // Region2 TOR locked, top 0x4000
      csr_wr(0, 12'h3b2, 32'h1000);
      csr_wr(0, 12'h3a0, 32'h00881c09);
      csr_wr(0, 12'h3b1, 32'h123);
      csr_wr(0, 12'h3b2, 32'h5);
      csr_wr(0, 12'h3a0, 32'h00001c0b);
      csr_wr(0, 12'h3b3, 32'h2000);
      csr_chk(0, "lock.addr1", 12'h3b1, 32'h81f);
      csr_chk(0, "lock.addr2", 12'h3b2, 32'h1000);
      csr_chk(0, "lock.cfg0", 12'h3a0, 32'h00881c0b);
      csr_chk(0, "lock.addr3", 12'h3b3, 32'h2000);
      query("lock_m_w", 32'h3000, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 5'd2);
      query("lock_m_x", 32'h3000, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 5'd2);

      // Query coincident with a CSR write sees the old config
      cfg_addr0 = 12'h3b0; cfg_wdata0 = 32'h800; cfg_wen0 = 1'b1;
      query("pre_write", 32'h1000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'h1f);
      cfg_wen0 = 1'b0;
      query("post_write", 32'h1000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);

      // Fault capture: sticky first fault, then clear racing a new fault
      csr_chk(0, "sticky.faddr", 12'hbd0, 32'h1000);
      csr_chk(0, "sticky.finfo", 12'hbd1, 32'h1f1);
      csr_wr(0, 12'hbd1, 32'h1);
      csr_chk(0, "clr2.finfo", 12'hbd1, 32'h0);
      query("fault_a", 32'h5000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'h1f);
      query("fault_b", 32'h6000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'h1f);
      tick();
      csr_chk(0, "two.faddr", 12'hbd0, 32'h5000);
      csr_chk(0, "two.finfo", 12'hbd1, 32'h1f1);
      query("fault_c", 32'h7000, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 5'h1f);
      csr_wr(0, 12'hbd1, 32'h1);
      csr_chk(0, "race.faddr", 12'hbd0, 32'h7000);
      csr_chk(0, "race.finfo", 12'hbd1, 32'h1f3);
      csr_wr(0, 12'hbd1, 32'h1);
      csr_chk(0, "clr3.finfo", 12'hbd1, 32'h0);
      csr_chk(0, "clr3.faddr", 12'hbd0, 32'h0);

      // G=2 unit: granule readback and WARL A field
      csr_wr(1, 12'h3a0, 32'h18);
      csr_wr(1, 12'h3b0, 32'h1002);
      csr_chk(1, "g2.napot_addr", 12'h3b0, 32'h1003);
      csr_chk(1, "g2.napot_cfg", 12'h3a0, 32'h18);
      csr_wr(1, 12'h3a0, 32'h00);
      csr_chk(1, "g2.off_addr", 12'h3b0, 32'h1000);
      csr_wr(1, 12'h3a0, 32'h10);
      csr_chk(1, "g2.na4_cfg", 12'h3a0, 32'h00);
      csr_wr(1, 12'h3a0, 32'h08);
      csr_chk(1, "g2.tor_cfg", 12'h3a0, 32'h08);
      csr_chk(1, "g2.tor_addr", 12'h3b0, 32'h1000);
      csr_wr(1, 12'h3a1, 32'hffffffff);
      csr_wr(1, 12'h3b5, 32'h1234);
      csr_chk(1, "g2.unimpl_cfg", 12'h3a1, 32'h0);
      csr_chk(1, "g2.unimpl_addr", 12'h3b5, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
